// File: rtl/vga_timing_pkg.sv
// Shared constants and region encoding for the 1024x768@60 raster timing generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_OFF = 11'h7FF;

  typedef enum logic [1:0] {
    ACT = 2'd0,
    FP  = 2'd1,
    SYN = 2'd2,
    BP  = 2'd3
  } region_e;

  // Region the counter enters when it takes the value cnt; holds otherwise.
  function automatic region_e region_step(input logic [COORD_W-1:0] cnt,
                                          input region_e             cur,
                                          input int unsigned         act_len,
                                          input int unsigned         fp_len,
                                          input int unsigned         sync_len);
    region_e r;
    r = cur;
    if (cnt == '0)
      r = ACT;
    else if (cnt == COORD_W'(act_len))
      r = FP;
    else if (cnt == COORD_W'(act_len + fp_len))
      r = SYN;
    else if (cnt == COORD_W'(act_len + fp_len + sync_len))
      r = BP;
    return r;
  endfunction

endpackage

// File: rtl/ce_delay_line.sv
// Clock-enabled shift register with a reset value per bit; DEPTH = 0 is a wire.
module ce_delay_line #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  if (DEPTH == 0) begin : g_bypass
    assign dout_o = din_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (ce) begin
        stage_q[0] <= din_i;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: h/v counters with region tracking, forced-off-range
// coordinates in blanking, and sync/active delayed to line up with the rgb lookup.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic               line_start
);

  localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic        SYNC_OFF = ~SYNC_POL;
  localparam logic [2:0]  SYNC_RST = {1'b0, SYNC_OFF, SYNC_OFF};

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  region_e            h_reg_q, h_reg_d;
  region_e            v_reg_q, v_reg_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               fs_q, fs_d;
  logic               ls_q, ls_d;
  logic [2:0]         sync_q, sync_d;
  logic [2:0]         sync_dly;
  logic               visible_c;
  logic               h_wrap_c;
  logic               v_wrap_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      h_reg_q <= ACT;
      v_reg_q <= ACT;
      x_q     <= COORD_OFF;
      y_q     <= COORD_OFF;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      sync_q  <= SYNC_RST;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      h_reg_q <= h_reg_d;
      v_reg_q <= v_reg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      sync_q  <= sync_d;
    end
  end

  // Counter/region advance and first output stage; start pulses self-clear.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    h_reg_d   = h_reg_q;
    v_reg_d   = v_reg_q;
    x_d       = x_q;
    y_d       = y_q;
    fs_d      = 1'b0;
    ls_d      = 1'b0;
    sync_d    = sync_q;
    visible_c = (h_reg_q == ACT) && (v_reg_q == ACT);
    h_wrap_c  = (h_cnt_q == COORD_W'(HT - 1));
    v_wrap_c  = (v_cnt_q == COORD_W'(VT - 1));
    if (ce) begin
      h_cnt_d = h_wrap_c ? '0 : h_cnt_q + COORD_W'(1);
      h_reg_d = region_step(h_cnt_d, h_reg_q, H_ACTIVE, H_FP, H_SYNC);
      if (h_wrap_c) begin
        v_cnt_d = v_wrap_c ? '0 : v_cnt_q + COORD_W'(1);
        v_reg_d = region_step(v_cnt_d, v_reg_q, V_ACTIVE, V_FP, V_SYNC);
      end
      x_d    = visible_c ? h_cnt_q : COORD_OFF;
      y_d    = visible_c ? v_cnt_q : COORD_OFF;
      fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
      ls_d   = (h_cnt_q == '0) && (v_reg_q == ACT);
      sync_d = {visible_c,
                (h_reg_q == SYN) ? SYNC_POL : SYNC_OFF,
                (v_reg_q == SYN) ? SYNC_POL : SYNC_OFF};
    end
  end

  ce_delay_line #(
    .WIDTH  (3),
    .DEPTH  (SYNC_DELAY),
    .RST_VAL(SYNC_RST)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .din_i (sync_q),
    .dout_o(sync_dly)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign active      = sync_dly[2];
  assign hsync       = sync_dly[1];
  assign vsync       = sync_dly[0];

endmodule
